// File: rtl/tvip_axi_burst_addr_gen.sv
// Expands one AXI4 / AXI4-Lite address command into per-beat descriptors
// (address, index, last, strobe). Illegal commands produce an error pulse.
module tvip_axi_burst_addr_gen #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int PROTOCOL   = 0,
  localparam int DB        = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [7:0]            beat_idx,
  output logic                  beat_last,
  output logic [DB-1:0]         beat_strb,
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic [ID_WIDTH-1:0]   err_id
);

  localparam int LOG2_DB = $clog2(DB);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state;
  logic [7:0]            r_len;
  logic [1:0]            r_burst;
  logic [ADDR_WIDTH-1:0] r_mask;
  logic [ADDR_WIDTH-1:0] r_span;
  logic [ADDR_WIDTH-1:0] r_lower;

  logic [7:0]            acc_len;
  logic [2:0]            acc_size;
  logic [1:0]            acc_burst;
  logic [ADDR_WIDTH-1:0] acc_mask;
  logic [ADDR_WIDTH-1:0] acc_span;
  logic [20:0]           end_off;
  logic [2:0]            acc_err;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_nxt;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic                  cmd_fire;
  logic                  beat_fire;

  // AXI4-Lite commands are treated as a single full-width INCR beat.
  assign acc_len   = (PROTOCOL != 0) ? 8'd0 : cmd_len;
  assign acc_size  = (PROTOCOL != 0) ? 3'(LOG2_DB) : cmd_size;
  assign acc_burst = (PROTOCOL != 0) ? BURST_INCR : cmd_burst;
  assign acc_mask  = (ADDR_WIDTH'(1) << acc_size) - ADDR_WIDTH'(1);
  assign acc_span  = ADDR_WIDTH'({1'b0, acc_len} + 9'd1) << acc_size;
  assign end_off   = 21'(cmd_addr[11:0]) + 21'(acc_span)
                   - 21'(cmd_addr[11:0] & acc_mask[11:0]);

  assign cmd_ready = (state == IDLE) || (beat_valid && beat_ready && beat_last);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign beat_fire = beat_valid && beat_ready;

  always_comb begin
    acc_err = 3'd0;
    if (int'(acc_size) > LOG2_DB)
      acc_err = 3'd1;
    else if (acc_burst == BURST_RSVD)
      acc_err = 3'd5;
    else if (acc_burst == BURST_WRAP && !(acc_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      acc_err = 3'd2;
    else if (acc_burst == BURST_WRAP && (cmd_addr & acc_mask) != '0)
      acc_err = 3'd4;
    else if (acc_burst == BURST_INCR && end_off > 21'd4096)
      acc_err = 3'd3;
  end

  always_comb begin
    step     = r_mask + ADDR_WIDTH'(1);
    wrap_nxt = beat_addr + step;
    nxt_addr = beat_addr;
    case (r_burst)
      BURST_FIXED: nxt_addr = beat_addr;
      BURST_INCR:  nxt_addr = (beat_addr & ~r_mask) + step;
      BURST_WRAP:  nxt_addr = (wrap_nxt == r_lower + r_span) ? r_lower : wrap_nxt;
      default:     nxt_addr = beat_addr;
    endcase
  end

  // Lanes from the byte address up to the end of the aligned transfer slot.
  function automatic logic [DB-1:0] calc_strb(input logic [ADDR_WIDTH-1:0] a,
                                              input logic [ADDR_WIDTH-1:0] m);
    logic [ADDR_WIDTH-1:0] lo;
    logic [ADDR_WIDTH-1:0] hi;
    logic [DB-1:0]         s;
    lo = a & ADDR_WIDTH'(DB - 1);
    hi = ((a & ~m) & ADDR_WIDTH'(DB - 1)) + m;
    for (int i = 0; i < DB; i++)
      s[i] = (ADDR_WIDTH'(i) >= lo) && (ADDR_WIDTH'(i) <= hi);
    return s;
  endfunction

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      r_len      <= '0;
      r_burst    <= '0;
      r_mask     <= '0;
      r_span     <= '0;
      r_lower    <= '0;
      beat_valid <= 1'b0;
      beat_id    <= '0;
      beat_addr  <= '0;
      beat_idx   <= '0;
      beat_last  <= 1'b0;
      beat_strb  <= '0;
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_id     <= '0;
    end else begin
      err_valid <= 1'b0;
      if (beat_fire) begin
        if (beat_last) begin
          beat_valid <= 1'b0;
          state      <= IDLE;
        end else begin
          beat_addr <= nxt_addr;
          beat_idx  <= beat_idx + 8'd1;
          beat_last <= (beat_idx + 8'd1 == r_len);
          beat_strb <= calc_strb(nxt_addr, r_mask);
        end
      end
      // A new command can only be accepted in IDLE or on the final beat handshake.
      if (cmd_fire) begin
        if (acc_err == 3'd0) begin
          state      <= BURST;
          beat_valid <= 1'b1;
          beat_id    <= cmd_id;
          beat_addr  <= cmd_addr;
          beat_idx   <= 8'd0;
          beat_last  <= (acc_len == 8'd0);
          beat_strb  <= calc_strb(cmd_addr, acc_mask);
          r_len      <= acc_len;
          r_burst    <= acc_burst;
          r_mask     <= acc_mask;
          r_span     <= acc_span;
          r_lower    <= cmd_addr & ~(acc_span - ADDR_WIDTH'(1));
        end else begin
          err_valid <= 1'b1;
          err_code  <= acc_err;
          err_id    <= cmd_id;
        end
      end
    end
  end

endmodule
